// File: rtl/traffic_light_pkg.sv
// traffic_light_pkg: state encoding, default phase lengths and lamp decode
package traffic_light_pkg;
  typedef enum logic [2:0] {
    ALLRED_TO_NS = 3'd0,
    NS_GREEN     = 3'd1,
    NS_YELLOW    = 3'd2,
    ALLRED_TO_EW = 3'd3,
    EW_GREEN     = 3'd4,
    EW_YELLOW    = 3'd5
  } state_e;
  localparam int DEF_GREEN_TICKS  = 5;
  localparam int DEF_YELLOW_TICKS = 2;
  localparam int DEF_ALLRED_TICKS = 1;
  localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001;
  function automatic logic [5:0] lamp_decode(input state_e s);
    return s == NS_GREEN  ? {GRN, RED} :
           s == NS_YELLOW ? {YEL, RED} :
           s == EW_GREEN  ? {RED, GRN} :
           s == EW_YELLOW ? {RED, YEL} : {RED, RED};
  endfunction
  function automatic state_e next_state(input state_e s);
    return s == EW_YELLOW ? ALLRED_TO_NS : state_e'(s + 3'd1);
  endfunction
endpackage

// File: rtl/traffic_light_if.sv
// traffic_light_if: the six lamp drives of both roads
interface traffic_light_if;
  logic ns_red, ns_yellow, ns_green;
  logic ew_red, ew_yellow, ew_green;
  modport master(output ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green);
  modport slave(input ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green);
endinterface

// File: rtl/traffic_light_phase_timer.sv
// tl_phase_timer: counts cycles in a phase, flags the last one and wraps to 0
module tl_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             done_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign done_o = cnt_q == limit_i;
  // next count: restart on explicit clear or at end of phase
  always_comb cnt_d = (clr_i || done_o) ? '0 : cnt_q + 1'b1;
  // counter register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/traffic_light.sv
// traffic_light: two-road Moore signal controller with timed phases
module traffic_light
  import traffic_light_pkg::*;
#(
  parameter int GREEN_TICKS  = DEF_GREEN_TICKS,
  parameter int YELLOW_TICKS = DEF_YELLOW_TICKS,
  parameter int ALLRED_TICKS = DEF_ALLRED_TICKS,
  parameter int CNT_W        = 8
) (
  input logic             clk,
  input logic             rst,
  traffic_light_if.master lamps
);
  localparam logic [CNT_W-1:0] G_LIM = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] Y_LIM = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] A_LIM = CNT_W'(ALLRED_TICKS - 1);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] limit;
  logic             illegal, done;
  tl_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (illegal),
    .limit_i(limit),
    .done_o (done)
  );
  // phase length for the current state and next-state selection
  always_comb begin
    illegal = state_q > EW_YELLOW;
    limit   = (state_q == NS_GREEN  || state_q == EW_GREEN)  ? G_LIM :
              (state_q == NS_YELLOW || state_q == EW_YELLOW) ? Y_LIM : A_LIM;
    state_d = illegal ? ALLRED_TO_NS : done ? next_state(state_q) : state_q;
  end
  // state register
  always_ff @(posedge clk) state_q <= rst ? ALLRED_TO_NS : state_d;
  assign {lamps.ns_red, lamps.ns_yellow, lamps.ns_green,
          lamps.ew_red, lamps.ew_yellow, lamps.ew_green} = lamp_decode(state_q);
endmodule

// File: tb/tb_traffic_light.sv
// tb_traffic_light: randomized and directed checks of two controller configurations
module tb_traffic_light;
  logic clk = 0, rst = 1;
  int cmp = 0, err = 0, t = 1;
  always #5 clk = ~clk;
  traffic_light_if l0 ();
  traffic_light_if l1 ();
  traffic_light u0 (.clk(clk), .rst(rst), .lamps(l0));
  traffic_light #(.GREEN_TICKS(3), .YELLOW_TICKS(1), .ALLRED_TICKS(2)) u1 (.clk(clk), .rst(rst), .lamps(l1));

  function automatic logic [5:0] model(input int tt, input int g, input int y, input int a);
    int half, p, q;
    logic [2:0] go;
    half = g + y + a;
    p = (tt - 1) % (2 * half);
    q = p % half;
    if (q < a) return 6'b100100;
    go = (q < a + g) ? 3'b001 : 3'b010;
    return p < half ? {go, 3'b100} : {3'b100, go};
  endfunction
  function automatic logic [5:0] act0();
    return {l0.ns_red, l0.ns_yellow, l0.ns_green, l0.ew_red, l0.ew_yellow, l0.ew_green};
  endfunction
  function automatic logic [5:0] act1();
    return {l1.ns_red, l1.ns_yellow, l1.ns_green, l1.ew_red, l1.ew_yellow, l1.ew_green};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
    t = rst ? 1 : t + 1;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) begin
      step();
      cmp++;
      if (act0() !== 6'b100100 || act1() !== 6'b100100) begin
        err++;
        $display("FAIL reset: got %b / %b, want 100100", act0(), act1());
      end
    end
  endtask

  task automatic test_nominal();
    rst = 1;
    step();
    rst = 0;
    repeat (40) begin
      cmp++;
      if (act0() !== model(t, 5, 2, 1) || act1() !== model(t, 3, 1, 2)) begin
        err++;
        $display("FAIL nominal t=%0d: got %b / %b, want %b / %b", t, act0(), act1(), model(t, 5, 2, 1), model(t, 3, 1, 2));
      end
      step();
    end
  endtask

  task automatic test_safety();
    logic [5:0] p0, p1, c0, c1;
    p0 = act0();
    p1 = act1();
    repeat (60) begin
      step();
      c0 = act0();
      c1 = act1();
      cmp++;
      if (!$onehot(c0[5:3]) || !$onehot(c0[2:0]) || !$onehot(c1[5:3]) || !$onehot(c1[2:0]) ||
          (!c0[5] && !c0[2]) || (!c1[5] && !c1[2]) ||
          (p0[3] && c0[5]) || (p0[0] && c0[2]) || (p1[3] && c1[5]) || (p1[0] && c1[2]) ||
          (p0[5] != c0[5] && !c0[5] && !p0[2]) || (p0[2] != c0[2] && !c0[2] && !p0[5])) begin
        err++;
        $display("FAIL safety t=%0d: got %b->%b / %b->%b, want legal lamp sequence", t, p0, c0, p1, c1);
      end
      p0 = c0;
      p1 = c1;
    end
  endtask

  task automatic test_mid_reset();
    rst = 1;
    step();
    rst = 0;
    repeat (3) step();
    cmp++;
    if (act0() !== 6'b001100) begin
      err++;
      $display("FAIL mid_reset_pre: got %b, want 001100", act0());
    end
    rst = 1;
    step();
    rst = 0;
    cmp++;
    if (act0() !== 6'b100100) begin
      err++;
      $display("FAIL mid_reset_red: got %b, want 100100", act0());
    end
    repeat (5) begin
      step();
      cmp++;
      if (act0() !== 6'b001100) begin
        err++;
        $display("FAIL mid_reset_green t=%0d: got %b, want 001100", t, act0());
      end
    end
    step();
    cmp++;
    if (act0() !== 6'b010100) begin
      err++;
      $display("FAIL mid_reset_yellow: got %b, want 010100", act0());
    end
  endtask

  task automatic test_override();
    logic [5:0] ov [13];
    ov = '{6'b100100, 6'b100100, 6'b001100, 6'b001100, 6'b001100, 6'b010100, 6'b100100,
           6'b100100, 6'b100001, 6'b100001, 6'b100001, 6'b100010, 6'b100100};
    rst = 1;
    step();
    rst = 0;
    for (int i = 0; i < 13; i++) begin
      cmp++;
      if (act1() !== ov[i]) begin
        err++;
        $display("FAIL override t=%0d: got %b, want %b", i + 1, act1(), ov[i]);
      end
      step();
    end
  endtask

  task automatic test_random_reset();
    repeat (300) begin
      rst = $urandom_range(0, 15) == 0;
      step();
      cmp++;
      if (act0() !== model(t, 5, 2, 1) || act1() !== model(t, 3, 1, 2)) begin
        err++;
        $display("FAIL random t=%0d: got %b / %b, want %b / %b", t, act0(), act1(), model(t, 5, 2, 1), model(t, 3, 1, 2));
      end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_safety();
    test_mid_reset();
    test_override();
    test_random_reset();
    test_safety();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
